keypad_scan: RTL
================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: sw_clk cycles each row is driven; legal range >=4.
REQ-002 Parameter DEB_FRAMES, default 4: consecutive identical scan frames needed to accept a press or a release; legal range >=1.
REQ-003 Parameter STROBE_LEN, default 2: sw_clk cycles eBCD[4] is held high per key event; legal range >=1.
REQ-004 sw_clk  in  1  single system clock; every flop is on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 key_col  in  4  matrix column lines, active-low, externally pulled up, asynchronous to sw_clk.
REQ-007 key_row  out  4  matrix row drive, one-hot active-low.
REQ-008 eBCD  out  5  key event: bit4 is the strobe (consumer acts on its rising edge), bits3:0 are the key code.
REQ-009 key_busy  out  1  high from acceptance of a press until its debounced release.

Function
REQ-010 key_col SHALL pass through a two-flop synchronizer before any use.
REQ-011 Row scan:
- row index r advances 0->1->2->3->0, every SCAN_DIV cycles;
- key_row = all ones except bit r = 0;
- columns sampled on the last cycle of each row period only;
- one frame = 4 row periods.
REQ-012 Frame result, evaluated at frame end:
- NONE: no column low in any row;
- SINGLE(code): exactly one (row, col) low; code = KEYMAP[{r, c}];
- MULTI: two or more low.
REQ-013 FSM states: IDLE, DEBOUNCE, SETUP, STROBE, RELEASE.
REQ-014 IDLE: on a SINGLE frame, latch the candidate code, set the frame counter to 1, go to DEBOUNCE; NONE and MULTI stay in IDLE.
REQ-015 DEBOUNCE:
- SINGLE with the same code increments the counter;
- when the counter reaches DEB_FRAMES, go to SETUP (with DEB_FRAMES=1, go to SETUP directly from IDLE);
- SINGLE with a different code restarts the count with the new candidate;
- NONE returns to IDLE;
- MULTI goes to RELEASE with no event emitted.
REQ-016 SETUP, 1 cycle: eBCD[3:0] = code, eBCD[4] = 0, key_busy = 1.
REQ-017 STROBE: eBCD[4] = 1 for exactly STROBE_LEN cycles; eBCD[3:0] is stable from SETUP until 1 cycle after eBCD[4] falls.
REQ-018 RELEASE: return to IDLE only after DEB_FRAMES consecutive NONE frames; any key frame restarts the count; key_busy falls on the transition to IDLE.
REQ-019 Exactly one event per physical press; no auto-repeat, whatever the hold time.
REQ-020 Scanning SHALL continue uninterrupted in all states; FSM state never stalls the row counter.
REQ-021 Press-to-strobe latency is DEB_FRAMES frames, counted from the first frame that sees the key, plus 1 SETUP cycle.
REQ-022 A press arriving in the middle of a frame SHALL NOT count until a full frame has seen it.
REQ-023 Counters wrap only via explicit reload; the frame counter saturates at DEB_FRAMES.

Reset
REQ-024 While rst = 0:
- state = IDLE, row index = 0, key_row = 4'b1110;
- eBCD = 5'b00000, key_busy = 0;
- all counters, the synchronizer and the candidate code cleared.
REQ-025 Reset asserted mid-STROBE SHALL drop eBCD[4] immediately (asynchronously) and emit no partial event.
REQ-026 After reset release, a key already held SHALL be treated as a new press: full debounce, then one event.

Structure
REQ-027 Shared package keypad_pkg holds:
- KEYMAP, a 16x4 constant: physical {row, col} to code, with 0-9 digits, a=/%, b=*, c=+-, d=AC, e=ans, f==;
- the FSM state enum;
- code localparams for the operator keys.
REQ-028 One sub-module, sync2: a parameterized-width two-flop synchronizer used for key_col.

Verification
(Bench parameters: SCAN_DIV=4, DEB_FRAMES=2, STROBE_LEN=2; one frame = 16 cycles.)
REQ-029 Hold physical key {row 1, col 2}, mapping to code 6, for 10 frames:
- exactly one eBCD[4] pulse, 2 cycles wide;
- eBCD[3:0] = 4'h6 one cycle before the rise and through the fall+1 cycle;
- key_busy high until 2 NONE frames after release.
REQ-030 Chatter: toggle key_col[0] every 3 cycles for 3 frames, then hold steady -> no event during chatter; exactly one event 2 full frames after it settles.
REQ-031 Two keys held simultaneously (rows 0 and 2) -> no event; after both are released, a single press of '=' yields eBCD[3:0] = 4'hf.
REQ-032 Assert rst during the first STROBE cycle -> eBCD = 0 and key_row = 4'b1110 in the same cycle; after release with the key still held, one fresh event after 2 frames plus 1 cycle.
REQ-033 Key held for 1 frame only, then released -> no event; state returns to IDLE; key_busy never asserted.
REQ-034 Sixteen sequential presses, each separated by 3 NONE frames -> emitted codes 0..f match KEYMAP; row drive is always one-hot-low.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad types and constants: the physical-key-to-code map, the
// event FSM states and the frame classification.
package keypad_pkg;

  localparam logic [3:0] KEY_DIV = 4'ha;
  localparam logic [3:0] KEY_MUL = 4'hb;
  localparam logic [3:0] KEY_PM  = 4'hc;
  localparam logic [3:0] KEY_AC  = 4'hd;
  localparam logic [3:0] KEY_ANS = 4'he;
  localparam logic [3:0] KEY_EQ  = 4'hf;

  // Indexed by {row, col}; calculator layout, row 0 at the top.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h7, 4'h8,    4'h9,   KEY_DIV,
    4'h4, 4'h5,    4'h6,   KEY_MUL,
    4'h1, 4'h2,    4'h3,   KEY_PM,
    4'h0, KEY_ANS, KEY_EQ, KEY_AC
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_e;

endpackage

// File: rtl/keypad_scan_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs.
module sync2 #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         sw_clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_p0;
  logic [W-1:0] sync_p1;

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row scan, per-frame classification, debounce
// and a single strobed key event per physical press.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_FRAMES = 4,
  parameter int STROBE_LEN = 2
) (
  input  logic       sw_clk,
  input  logic       rst,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [4:0] eBCD,
  output logic       key_busy
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEB_FRAMES + 1);
  localparam int STB_W = $clog2(STROBE_LEN + 1);

  function automatic logic [1:0] hits_sat(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd2) ? 2'd2 : s[1:0];
  endfunction

  function automatic logic [DEB_W-1:0] deb_sat_inc(input logic [DEB_W-1:0] x);
    return (x >= DEB_W'(DEB_FRAMES)) ? x : x + DEB_W'(1);
  endfunction

  logic [3:0]       col_s;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       row_idx;
  logic             row_end;
  logic             frame_end;

  logic [1:0]       row_hits;
  logic [1:0]       row_col;
  logic [1:0]       acc_hits;
  logic [3:0]       acc_idx;
  logic [1:0]       tot_hits;
  logic [3:0]       cur_idx;
  frame_e           frame_res;
  logic [3:0]       fr_code;

  kp_state_e        state, state_n;
  logic [3:0]       cand_code, cand_n;
  logic [DEB_W-1:0] deb_cnt, deb_n;
  logic [STB_W-1:0] stb_cnt, stb_n;
  logic [3:0]       out_code;
  logic             strobe_q;
  logic             busy_q;

  // Reset to the released level so a reset never looks like a press.
  sync2 #(
    .W       (4),
    .RST_VAL (4'hF)
  ) u_col_sync (
    .sw_clk (sw_clk),
    .rst    (rst),
    .d      (key_col),
    .q      (col_s)
  );

  // Stage: row scan timing, free running in every FSM state.
  assign row_end   = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end = row_end && (row_idx == 2'd3);
  assign key_row   = ~(4'b0001 << row_idx);

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      row_idx <= 2'd0;
    end else if (row_end) begin
      div_cnt <= '0;
      row_idx <= (row_idx == 2'd3) ? 2'd0 : row_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Stage: column sampling and frame accumulation.
  always_comb begin
    row_hits = 2'd0;
    row_col  = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!col_s[c]) begin
        row_hits = hits_sat(row_hits, 2'd1);
        row_col  = 2'(c);
      end
    end
    tot_hits = hits_sat(acc_hits, row_hits);
    cur_idx  = (row_hits != 2'd0) ? {row_idx, row_col} : acc_idx;
    fr_code  = KEYMAP[cur_idx];
    case (tot_hits)
      2'd0:    frame_res = FR_NONE;
      2'd1:    frame_res = FR_SINGLE;
      default: frame_res = FR_MULTI;
    endcase
  end

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      acc_hits <= 2'd0;
      acc_idx  <= 4'd0;
    end else if (frame_end) begin
      acc_hits <= 2'd0;
      acc_idx  <= 4'd0;
    end else if (row_end) begin
      acc_hits <= tot_hits;
      acc_idx  <= cur_idx;
    end
  end

  // Stage: event FSM, frame-driven except for the SETUP/STROBE timing.
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    cand_n  = cand_code;
    deb_n   = deb_cnt;
    stb_n   = stb_cnt;
    case (state)
      ST_IDLE: begin
        if (frame_end && frame_res == FR_SINGLE) begin
          cand_n  = fr_code;
          deb_n   = DEB_W'(1);
          state_n = (DEB_FRAMES <= 1) ? ST_SETUP : ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (frame_end) begin
          case (frame_res)
            FR_NONE: begin
              state_n = ST_IDLE;
              deb_n   = '0;
            end
            FR_SINGLE: begin
              if (fr_code == cand_code) begin
                deb_n = deb_sat_inc(deb_cnt);
                if (deb_sat_inc(deb_cnt) == DEB_W'(DEB_FRAMES)) state_n = ST_SETUP;
              end else begin
                cand_n = fr_code;
                deb_n  = DEB_W'(1);
              end
            end
            default: begin
              state_n = ST_RELEASE;
              deb_n   = '0;
            end
          endcase
        end
      end
      ST_SETUP: begin
        state_n = ST_STROBE;
        stb_n   = STB_W'(1);
      end
      ST_STROBE: begin
        if (stb_cnt >= STB_W'(STROBE_LEN)) begin
          state_n = ST_RELEASE;
          deb_n   = '0;
        end else begin
          stb_n = stb_cnt + STB_W'(1);
        end
      end
      ST_RELEASE: begin
        if (frame_end) begin
          if (frame_res == FR_NONE) begin
            deb_n = deb_sat_inc(deb_cnt);
            if (deb_sat_inc(deb_cnt) == DEB_W'(DEB_FRAMES)) begin
              state_n = ST_IDLE;
              deb_n   = '0;
            end
          end else begin
            deb_n = '0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Stage: registered event outputs.
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      cand_code <= 4'd0;
      deb_cnt   <= '0;
      stb_cnt   <= '0;
      out_code  <= 4'd0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cand_code <= cand_n;
      deb_cnt   <= deb_n;
      stb_cnt   <= stb_n;
      strobe_q  <= (state_n == ST_STROBE);
      if (state_n == ST_SETUP) begin
        out_code <= cand_n;
        busy_q   <= 1'b1;
      end else if (state_n == ST_IDLE) begin
        busy_q   <= 1'b0;
      end
    end
  end

  assign eBCD     = {strobe_q, out_code};
  assign key_busy = busy_q;

  a_strobe_busy : assert property (@(posedge sw_clk) disable iff (!rst) eBCD[4] |-> key_busy);
  a_row_onehot  : assert property (@(posedge sw_clk) disable iff (!rst) $onehot(~key_row));

endmodule
